// File: rtl/main_mem_responder_pkg.sv
// Shared types and constants for the main-memory responder and its bus.
package main_mem_responder_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;

    // Same encoding as the cache's target-side port.
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10
    } state_e;

endpackage

// File: rtl/main_mem_responder_if.sv
// Request/response bus between the cache's miss port and the backing store,
// plus the debug view of the first four memory words.
interface main_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic [DATA_W-1:0] ram0;
    logic [DATA_W-1:0] ram1;
    logic [DATA_W-1:0] ram2;
    logic [DATA_W-1:0] ram3;

    modport master (
        output req, rw, addr, wdata,
        input  rdata, ack, busy, ram0, ram1, ram2, ram3
    );

    modport slave (
        input  req, rw, addr, wdata,
        output rdata, ack, busy, ram0, ram1, ram2, ram3
    );
endinterface

// File: rtl/main_mem_responder_mem_array.sv
// Word-addressed storage: synchronous write, reset loads mem[i] = i,
// one combinational read port and four debug taps on words 0..3.
module main_mem_responder_mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdout,
    output logic [DATA_W-1:0] ram0,
    output logic [DATA_W-1:0] ram1,
    output logic [DATA_W-1:0] ram2,
    output logic [DATA_W-1:0] ram3
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            // Each word resets to its own index; reset wins over a pending write.
            always_ff @(posedge clk) begin
                if (clr) begin
                    mem_q[gi] <= DATA_W'(gi);
                end else if (we && (waddr == ADDR_W'(gi))) begin
                    mem_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdout = mem_q[raddr];
    assign ram0  = mem_q[0];
    assign ram1  = mem_q[1];
    assign ram2  = mem_q[2];
    assign ram3  = mem_q[3];

endmodule

// File: rtl/main_mem_responder.sv
// Backing-store responder: captures one request in IDLE, waits LATENCY
// cycles, performs the access, then holds ack until req drops.
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = 4            // 1..15
) (
    input  logic           clk,
    input  logic           clr,
    main_mem_responder_if.slave bus
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we;
    logic [DATA_W-1:0] rd_word;

    main_mem_responder_mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .clk   (clk),
        .clr   (clr),
        .we    (we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdout (rd_word),
        .ram0  (bus.ram0),
        .ram1  (bus.ram1),
        .ram2  (bus.ram2),
        .ram3  (bus.ram3)
    );

    // State, latency counter and captured request.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= RW_READ;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic; request fields are only sampled in IDLE so that
    // anything the cache does to them mid-transaction is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    rw_d    = bus.rw;
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A dropped req here does not abort; the access still completes.
                if (cnt_q == '0) begin
                    if (rw_q == RW_WRITE) begin
                        we = 1'b1;
                    end else begin
                        rdata_d = rd_word;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = (state_q == ACK);
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Backing-store responder at the far end of the cache's miss/write-back port.
- The cache's target-side request (address, data, rw) is the initiator. This block is the slave that answers it.
- Models a 256 x 8 main memory with programmable access latency and a four-phase req/ack handshake.
- Exposes the first four words on debug outputs for bench visibility.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, data word width.
- LATENCY, 4, cycles from request capture to ack; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- clr  input  1  synchronous active-high reset.
- req  input  1  request from cache; held high until ack is seen.
- rw  input  1  1 = write, 0 = read; sampled with req.
- addr  input  ADDR_W  request address.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  read data; valid while ack=1 on a read.
- ack  output  1  transaction complete; held until req drops.
- busy  output  1  high in every state except IDLE.
- ram0, ram1, ram2, ram3  output  DATA_W each  continuous view of mem[0..3].

Behaviour:
- Clock and reset: one clock, clk. Reset clr is synchronous and active-high.
- Reset (clr=1 at posedge, overrides everything):
  - state=IDLE, counter=0, ack=0, busy=0, rdata=0.
  - mem[i] = i[DATA_W-1:0] for all i.
- States:
  - IDLE: ack=0, busy=0. If req=1, latch addr/rw/wdata into request registers, load cnt=LATENCY-1, go to WAIT.
  - WAIT: busy=1. If cnt==0, perform the access and go to ACK; else cnt<=cnt-1.
    - Write access: mem[addr_q]<=wdata_q. rdata is unchanged.
    - Read access: rdata<=mem[addr_q].
  - ACK: ack=1, busy=1. If req=0, go to IDLE (ack falls on that edge); else stay.
- Latency: if the edge that samples req in IDLE is edge E, ack is first high after edge E+LATENCY.
  - Read data is valid in the same cycle ack rises.
  - A write is committed in memory on edge E+LATENCY.
- Latching: addr, rw and wdata are captured only in IDLE. Changes during WAIT/ACK are ignored.
- req dropped during WAIT (protocol violation): the transaction still completes.
  - ACK then lasts exactly one cycle, because req=0 is seen at the next edge.
  - No abort.
- Back-to-back transactions: the earliest new request is captured on the first IDLE edge after ack falls, i.e. a minimum of one IDLE cycle between transactions.
- Reset mid-operation:
  - In WAIT, a pending write is discarded and memory is re-initialised.
  - Outputs return to reset values on that edge.
- Address wrap: none needed; addr spans the full depth.
- Counter width: 4 bits.
- LATENCY=1: WAIT lasts one cycle (cnt loads 0).
- ram0..ram3 are combinational from the array and reflect a write on the edge it commits.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'b00, WAIT=2'b01, ACK=2'b10.
  - widths: ADDR_W and DATA_W defaults.
  - RW_READ=1'b0, RW_WRITE=1'b1, shared with the cache's target-side port.
- Sub-module mem_array:
  - synchronous-write storage of 2**ADDR_W words with synchronous-reset initialisation and one read port.
  - ports: clk, clr, we, waddr, wdata, raddr, rdout, plus the four debug taps.
- The FSM, counter and request registers stay in main_mem_responder.

Test Plan:
1. Reset then read: clr=1 for 2 cycles, then req=1, rw=0, addr=8'h05, LATENCY=4. Required: ack high 4 cycles after the capture edge, rdata=8'h05, busy high from capture to ack fall.
2. Write then read-back: write addr=8'h02, wdata=8'hC0, then read 8'h02. Required: write ack after 4 cycles, ram2=8'hC0 from the commit edge, read returns rdata=8'hC0.
3. Input changes ignored: req=1, rw=1, addr=8'h01, wdata=8'hE0. One cycle later change addr=8'h03 and wdata=8'h11 with req held. Required: mem[1]=8'hE0, ram3 stays 8'h03.
4. Early req drop: req pulsed for 1 cycle on a read of 8'hAA. Required: ack=1 for exactly one cycle after 4 cycles, rdata=8'hAA, return to IDLE.
5. Mid-operation reset: start a write of 8'h77 to 8'h00 and assert clr during WAIT. Required: ack never asserts, ram0=8'h00, busy=0 on the next edge.
6. Back-to-back with LATENCY=1: two reads (8'h10, 8'h20) with req re-asserted immediately after ack falls. Required: each ack rises 1 cycle after its capture edge, one IDLE cycle between transactions, rdata 8'h10 then 8'h20.
